// File: rtl/operand_sweep.sv
// Operand sweep generator: steps a 6-bit index across the A1/A2/A3 operands of a 2-bit logic stage.
// Define OPERAND_SWEEP_A3_EN to sweep all 64 vectors (A3 live); otherwise 16 vectors with A3 tied to 0.
module operand_sweep #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       step,
  output logic [1:0] A1,
  output logic [1:0] A2,
  output logic [1:0] A3,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [5:0] idx
);

`ifdef OPERAND_SWEEP_A3_EN
  localparam logic [5:0] LAST = 6'd63;
`else
  localparam logic [5:0] LAST = 6'd15;
`endif
  localparam logic [7:0] CNT_MAX = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [5:0] idx_nxt;
  logic       valid_nxt, busy_nxt, done_nxt;
  logic       beat_end;

  assign beat_end = step && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !abort) state_nxt = RUN;
      RUN: begin
        if (abort)                        state_nxt = IDLE;
        else if (beat_end && idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (abort)      state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next-value logic for the registered outputs; abort always lands on an all-zero IDLE.
  always_comb begin
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    valid_nxt = valid;
    busy_nxt  = busy;
    done_nxt  = done;
    case (state)
      IDLE, DONE: begin
        if (abort) begin
          idx_nxt = '0; cnt_nxt = '0; valid_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b0;
        end else if (start) begin
          idx_nxt = '0; cnt_nxt = '0; valid_nxt = 1'b1; busy_nxt = 1'b1; done_nxt = 1'b0;
        end else if (state == IDLE) begin
          idx_nxt = '0; cnt_nxt = '0; valid_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          idx_nxt = '0; cnt_nxt = '0; valid_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b0;
        end else if (beat_end) begin
          cnt_nxt = '0;
          if (idx == LAST) begin
            valid_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 6'd1;
          end
        end else if (step) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        idx_nxt = '0; cnt_nxt = '0; valid_nxt = 1'b0; busy_nxt = 1'b0; done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Operands are plain slices of the registered index.
  assign A2 = idx[1:0];
  assign A1 = idx[3:2];
`ifdef OPERAND_SWEEP_A3_EN
  assign A3 = idx[5:4];
`else
  assign A3 = 2'b00;
`endif

endmodule

// File: doc/operand_sweep.md
OPERAND_SWEEP -- requirements
Module: operand_sweep

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 1, meaning the number of step-qualified cycles each vector is held (legal 1..255).
REQ-002 SHALL provide port clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  begin a sweep (sampled in IDLE or DONE only).
REQ-005 SHALL provide port abort  input  1  terminate a running sweep.
REQ-006 SHALL provide port step  input  1  downstream ready; advance qualifier.
REQ-007 SHALL provide port A1  output  2  operand 1 to the downstream 2-bit logic stage.
REQ-008 SHALL provide port A2  output  2  operand 2.
REQ-009 SHALL provide port A3  output  2  operand 3.
REQ-010 SHALL provide port valid  output  1  A1/A2/A3 hold a live vector.
REQ-011 SHALL provide port busy  output  1  FSM in RUN.
REQ-012 SHALL provide port done  output  1  sweep completed; level until next start or reset.
REQ-013 SHALL provide port idx  output  6  current vector index.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 SHALL map idx to operands: A2 = idx[1:0], A1 = idx[3:2], A3 = idx[5:4].
REQ-016 IDLE: start=1 and abort=0 at edge k SHALL give RUN, idx=0, hold counter=0, valid=1, busy=1 visible after edge k (1-cycle latency).
REQ-017 RUN: hold counter SHALL increment only on cycles with step=1; step=0 freezes idx, counter and operands.
REQ-018 RUN: step=1 with counter=HOLD_CYCLES-1 and idx<LAST SHALL increment idx by 1 and clear the counter at that edge.
REQ-019 RUN: step=1 with counter=HOLD_CYCLES-1 and idx=LAST SHALL enter DONE: valid=0, busy=0, done=1, idx and operands hold last vector.
REQ-020 LAST SHALL be 15 (6'd15) or 63 per REQ-029/030; idx SHALL never wrap past LAST.
REQ-021 start in RUN SHALL be ignored.
REQ-022 abort=1 in RUN SHALL enter IDLE at next edge with all outputs 0, regardless of step.
REQ-023 abort and start both 1 in IDLE or DONE: abort SHALL win, FSM goes to/stays IDLE, done cleared.
REQ-024 DONE: start=1 SHALL restart exactly as REQ-016 and clear done the same edge.
REQ-025 abort in DONE SHALL return to IDLE and clear done.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, idx=0, counter=0, A1=A2=A3=0, valid=0, busy=0, done=0.
REQ-027 rst SHALL dominate start, abort and step, including mid-sweep.
REQ-028 Without a clock edge rst SHALL have no effect (synchronous).

Configuration
REQ-029 With macro OPERAND_SWEEP_A3_EN defined: LAST=63, A3 = idx[5:4], 64 vectors per sweep.
REQ-030 Without OPERAND_SWEEP_A3_EN: LAST=15, idx[5:4] and A3 held at 2'b00, 16 vectors per sweep.

Verification
REQ-031 Macro off, HOLD_CYCLES=1, step tied 1, start pulse -> vectors (A1,A2)=(0,0),(0,1)..(3,3) on 16 consecutive cycles, A3=0, done=1 on cycle 17.
REQ-032 HOLD_CYCLES=3, step toggling 1,0,1,0.. -> each vector held 6 cycles; idx=1 appears only after 3 step-high cycles.
REQ-033 Abort at idx=5 -> next cycle IDLE, A1=A2=A3=0, valid=0; later start resumes from idx=0.
REQ-034 rst asserted at idx=9 with start=1 -> all outputs 0 after that edge, FSM IDLE, done=0.
REQ-035 Macro on, step tied 1 -> 64 vectors, last A1=3 A2=3 A3=3, done then start in DONE restarts at idx=0 with done=0.
REQ-036 Start+abort simultaneously in DONE -> IDLE, done=0, valid=0.
